// File: rtl/shiftreg_pkg.sv
// Shared widths, FSM state type and div saturation helper for the
// configuration shift-register engine.
package shiftreg_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned DIV_WIDTH  = 4;
  localparam int unsigned CNT_WIDTH  = 16;
  localparam int unsigned NB_WIDTH   = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    LOAD = 2'd3
  } state_e;

  // Largest usable exponent is CNT_WIDTH-1 so 2**div-1 fits the counter.
  function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] div);
    if (32'(div) > CNT_WIDTH - 1) begin
      return DIV_WIDTH'(CNT_WIDTH - 1);
    end
    return div;
  endfunction

endpackage

// File: rtl/shiftreg_rw_engine_if.sv
// Control-side and chip-side signals of the shift-register engine.
interface shiftreg_rw_engine_if;
  import shiftreg_pkg::*;

  logic [DIV_WIDTH-1:0]  div;
  logic                  start;
  logic [NB_WIDTH-1:0]   nbits;
  logic [DATA_WIDTH-1:0] din;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] dout;
  logic                  sclk;
  logic                  sdo;
  logic                  sdi;
  logic                  sload;

  modport master (
    output div, start, nbits, din, sdi,
    input  busy, done, dout, sclk, sdo, sload
  );

  modport slave (
    input  div, start, nbits, din, sdi,
    output busy, done, dout, sclk, sdo, sload
  );

endinterface

// File: rtl/half_period_tick.sv
// Half-period timer: while clr_i is high it latches div and holds the count
// at zero; otherwise tick_c fires once every 2**eff_div(div) cycles.
module half_period_tick
  import shiftreg_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_c
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] lim_q, lim_d;

  assign tick_c = (cnt_q == lim_q);

  always_comb begin
    lim_d = lim_q;
    cnt_d = cnt_q + CNT_WIDTH'(1);
    if (clr_i) begin
      lim_d = (CNT_WIDTH'(1) << eff_div(div_i)) - CNT_WIDTH'(1);
      cnt_d = '0;
    end else if (tick_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

endmodule

// File: rtl/shiftreg_rw_engine.sv
// Serial read/write engine: shifts din out on sdo LSB-first while capturing
// sdi, strobes sload, then returns right-aligned read data with a done pulse.
module shiftreg_rw_engine
  import shiftreg_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_n,
  shiftreg_rw_engine_if.slave  bus
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [NB_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NB_WIDTH-1:0]   nb_q, nb_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sclk_q, sclk_d;
  logic                  sdo_q, sdo_d;
  logic                  sload_q, sload_d;
  logic                  tick_c;

  // Timer stays cleared in IDLE so the div present at the accept edge is the one used.
  half_period_tick u_tick (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clr_i  (state_q == IDLE),
    .div_i  (bus.div),
    .tick_c (tick_c)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    nb_d    = nb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    sload_d = sload_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.nbits != '0) begin
            nb_d    = (bus.nbits > NB_WIDTH'(DATA_WIDTH)) ? NB_WIDTH'(DATA_WIDTH) : bus.nbits;
            sr_d    = bus.din;
            cnt_d   = '0;
            busy_d  = 1'b1;
            sclk_d  = 1'b0;
            sdo_d   = bus.din[0];
            state_d = LOW;
          end else begin
            done_d = 1'b1;
            dout_d = '0;
          end
        end
      end
      LOW: begin
        if (tick_c) begin
          sr_d    = {bus.sdi, sr_q[DATA_WIDTH-1:1]};
          cnt_d   = cnt_q + NB_WIDTH'(1);
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick_c) begin
          sclk_d = 1'b0;
          if (cnt_q < nb_q) begin
            sdo_d   = sr_q[0];
            state_d = LOW;
          end else begin
            sdo_d   = 1'b0;
            sload_d = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (tick_c) begin
          sload_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Captured bits sit in the top nb_q positions; slide them down to bit 0.
          dout_d  = sr_q >> (NB_WIDTH'(DATA_WIDTH) - nb_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      nb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      sload_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      nb_q    <= nb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      sload_q <= sload_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.dout  = dout_q;
  assign bus.sclk  = sclk_q;
  assign bus.sdo   = sdo_q;
  assign bus.sload = sload_q;

endmodule

// File: tb/tb_shiftreg_rw_engine.sv
// Bench for shiftreg_rw_engine: a transfer-level timing model checked every
// cycle, plus directed transfers with hand-computed results.
module tb_shiftreg_rw_engine;
  import shiftreg_pkg::*;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  shiftreg_rw_engine_if bus ();

  shiftreg_rw_engine dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [31:0] mask(input int n);
    if (n >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << n) - 32'd1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transfer model: a transfer is 2n half-periods of bits plus one of load,
  // each H = 2**div cycles long, counted in edges since the accept edge.
  logic        m_active = 1'b0;
  logic        m_done   = 1'b0;
  logic [31:0] m_dout   = '0;
  logic [31:0] m_din    = '0;
  logic [31:0] m_sdi    = '0;
  int          m_e = 0, m_h = 1, m_n = 0;
  logic [31:0] tb_sdi_vec = '0;

  always @(posedge clk_in or negedge rst_n) begin
    int dv;
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_dout   = '0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_e++;
        if (m_e == (2 * m_n + 1) * m_h) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_dout   = m_sdi & mask(m_n);
        end
      end else if (bus.start) begin
        if (bus.nbits != 0) begin
          dv       = int'(bus.div);
          if (dv > int'(CNT_WIDTH) - 1) dv = int'(CNT_WIDTH) - 1;
          m_active = 1'b1;
          m_e      = 0;
          m_h      = 1 << dv;
          m_n      = (int'(bus.nbits) > int'(DATA_WIDTH)) ? int'(DATA_WIDTH) : int'(bus.nbits);
          m_din    = bus.din;
          m_sdi    = tb_sdi_vec;
        end else begin
          m_done = 1'b1;
          m_dout = '0;
        end
      end
    end
  end

  // Per-cycle compare against the model; also presents sdi bit k during low phase k.
  always @(negedge clk_in) begin
    int   p;
    logic e_busy, e_sclk, e_sdo, e_sload;
    e_busy = 1'b0; e_sclk = 1'b0; e_sdo = 1'b0; e_sload = 1'b0;
    if (m_active) begin
      p      = m_e / m_h;
      e_busy = 1'b1;
      if (p < 2 * m_n) begin
        e_sclk = p[0];
        e_sdo  = m_din[p/2];
        if (!p[0]) bus.sdi = m_sdi[p/2];
      end else begin
        e_sload = 1'b1;
      end
    end
    check("busy",  32'(bus.busy),  32'(e_busy));
    check("sclk",  32'(bus.sclk),  32'(e_sclk));
    check("sdo",   32'(bus.sdo),   32'(e_sdo));
    check("sload", 32'(bus.sload), 32'(e_sload));
    check("done",  32'(bus.done),  32'(m_done));
    check("dout",  bus.dout, m_dout);
  end

  // Waveform measurements for the hand-computed expectations.
  int          rises = 0, sload_len = 0;
  logic [31:0] sdo_cap = '0;
  logic        sclk_prev = 1'b0;
  always @(negedge clk_in) begin
    if (bus.sclk === 1'b1 && sclk_prev === 1'b0) begin
      if (rises < 32) sdo_cap[rises] = bus.sdo;
      rises++;
    end
    if (bus.sload === 1'b1) sload_len++;
    sclk_prev = bus.sclk;
  end

  task automatic clear_meas();
    rises = 0; sload_len = 0; sdo_cap = '0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      if (bus.done === 1'b1) begin ok = 1'b1; break; end
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    #1;
  endtask

  task automatic xfer(input string tag, input int dv, input int nb, input logic [31:0] d,
                      input logic [31:0] sv, input logic [31:0] exp_dout, input int exp_lat,
                      input int exp_rises, input int exp_sload);
    int t0;
    tb_sdi_vec = sv;
    bus.div    = DIV_WIDTH'(dv);
    bus.nbits  = NB_WIDTH'(nb);
    bus.din    = d;
    bus.start  = 1'b1;
    @(posedge clk_in); #1;
    bus.start = 1'b0;
    t0 = cyc;
    clear_meas();
    wait_done(tag);
    check({tag, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
    check({tag, "_dout"},    bus.dout, exp_dout);
    check({tag, "_rises"},   32'(rises), 32'(exp_rises));
    check({tag, "_sload"},   32'(sload_len), 32'(exp_sload));
    check({tag, "_sdo_seq"}, sdo_cap, d & mask(nb));
    @(posedge clk_in); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    bus.div = '0; bus.start = 1'b0; bus.nbits = '0; bus.din = '0; bus.sdi = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_sclk",  32'(bus.sclk),  32'd0);
    check("rst_sdo",   32'(bus.sdo),   32'd0);
    check("rst_sload", 32'(bus.sload), 32'd0);
    check("rst_dout",  bus.dout, 32'd0);
    rst_n = 1'b1;
    @(posedge clk_in); #1;

    xfer("t1", 0, 4,  32'h0000_000B, 32'h0000_0009, 32'h0000_0009, 9,   4,  1);
    xfer("t2", 2, 3,  32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0007, 28,  3,  4);
    xfer("t3", 1, 0,  32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_0000, 0,   0,  0);
    xfer("t4", 1, 40, 32'hA5C3_0F96, 32'h1234_5678, 32'h1234_5678, 130, 32, 2);

    // Stray start and a div change mid-transfer, then start held through done.
    tb_sdi_vec = 32'h5; bus.div = 4'd1; bus.nbits = 6'd3; bus.din = 32'h6; bus.start = 1'b1;
    @(posedge clk_in); #1;
    bus.start = 1'b0; t0 = cyc; clear_meas();
    repeat (3) begin @(posedge clk_in); #1; end
    bus.start = 1'b1;
    @(posedge clk_in); #1;
    bus.start = 1'b0; bus.div = 4'd3; bus.nbits = 6'd2; bus.din = 32'h1; tb_sdi_vec = 32'h2;
    repeat (2) begin @(posedge clk_in); #1; end
    bus.start = 1'b1;
    wait_done("t5a");
    check("t5a_latency", 32'(cyc - t0), 32'd14);
    check("t5a_dout",    bus.dout, 32'h5);
    check("t5a_rises",   32'(rises), 32'd3);
    @(posedge clk_in); #1;
    check("t5b_busy_b2b", 32'(bus.busy), 32'd1);
    bus.start = 1'b0; t0 = cyc; clear_meas();
    wait_done("t5b");
    check("t5b_latency", 32'(cyc - t0), 32'd40);
    check("t5b_dout",    bus.dout, 32'h2);
    check("t5b_rises",   32'(rises), 32'd2);
    @(posedge clk_in); #1;

    // Reset asserted during the high phase of bit 5.
    tb_sdi_vec = 32'hFF; bus.div = 4'd1; bus.nbits = 6'd8; bus.din = 32'hC3; bus.start = 1'b1;
    @(posedge clk_in); #1;
    bus.start = 1'b0;
    repeat (22) @(posedge clk_in);
    @(negedge clk_in);
    check("t6_pre_sclk", 32'(bus.sclk), 32'd1);
    check("t6_pre_busy", 32'(bus.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_sclk",  32'(bus.sclk),  32'd0);
    check("t6_sdo",   32'(bus.sdo),   32'd0);
    check("t6_busy",  32'(bus.busy),  32'd0);
    check("t6_sload", 32'(bus.sload), 32'd0);
    check("t6_dout",  bus.dout, 32'd0);
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    @(posedge clk_in); #1;

    xfer("t7", 1, 5, 32'h0000_0016, 32'h0000_000D, 32'h0000_000D, 22, 5, 2);

    repeat (3) @(posedge clk_in);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
